// File: rtl/cnt_pkg.sv
// Shared command encoding for tff_mod_counter and its toggle bank.
package cnt_pkg;

  localparam int unsigned CMD_W = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_HOLD = 2'd0,
    CMD_UP   = 2'd1,
    CMD_DOWN = 2'd2,
    CMD_LOAD = 2'd3
  } cmd_e;

endpackage

// File: rtl/tff_bank.sv
// Bank of WIDTH toggle cells: each bit flips when its mask bit is set.
module tff_bank #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q ^ mask;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_q <= WIDTH'(RST_VAL);
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/tff_mod_counter.sv
// Modulo-MOD up/down counter built on a toggle bank driven by a next-state mask.
// Define TFF_MOD_COUNTER_SATURATE_EN to saturate at the bounds instead of wrapping.
module tff_mod_counter
  import cnt_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MOD     = 2 ** WIDTH,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic [1:0]       cmd,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf,
  output logic             load_err
);

  // An out-of-range reset value is clamped so count never leaves 0..MOD-1.
  localparam int unsigned      RstSafe = (RST_VAL < MOD) ? RST_VAL : MOD - 1;
  localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   ModExt  = (WIDTH + 1)'(MOD);

  cmd_e             cmd_s;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] mask;
  logic             wrap_d, wrap_q;
  logic             ovf_d, ovf_q;
  logic             load_err_d, load_err_q;

  assign cmd_s = cmd_e'(cmd);

  always_comb begin
    next_count = count;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (clr) begin
      next_count = '0;
    end else begin
      unique case (cmd_s)
        CMD_LOAD: begin
          if ({1'b0, load_val} < ModExt) begin
            next_count = load_val;
          end else begin
            next_count = MaxVal;
            load_err_d = 1'b1;
          end
        end
        CMD_UP: begin
          if (count == MaxVal) begin
            wrap_d = 1'b1;
`ifdef TFF_MOD_COUNTER_SATURATE_EN
            next_count = MaxVal;
`else
            next_count = '0;
`endif
          end else begin
            next_count = count + WIDTH'(1);
          end
        end
        CMD_DOWN: begin
          if (count == '0) begin
            wrap_d = 1'b1;
`ifdef TFF_MOD_COUNTER_SATURATE_EN
            next_count = '0;
`else
            next_count = MaxVal;
`endif
          end else begin
            next_count = count - WIDTH'(1);
          end
        end
        CMD_HOLD: next_count = count;
      endcase
    end
    mask  = count ^ next_count;
    // A new wrap event takes precedence over a concurrent clear request.
    ovf_d = wrap_d | (ovf_q & ~ovf_clr);
  end

  tff_bank #(
    .WIDTH  (WIDTH),
    .RST_VAL(RstSafe)
  ) u_bank (
    .clk (clk),
    .rstn(rstn),
    .mask(mask),
    .q   (count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrap_q     <= 1'b0;
      ovf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      ovf_q      <= ovf_d;
      load_err_q <= load_err_d;
    end
  end

  assign tc = ~clr & (((cmd_s == CMD_UP) && (count == MaxVal)) ||
                      ((cmd_s == CMD_DOWN) && (count == '0)));

  assign wrap     = wrap_q;
  assign ovf      = ovf_q;
  assign load_err = load_err_q;

endmodule
